// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the instruction-fetch, load/store and unified-memory signals that
//   meet at mem_port_arbiter.
//   Modports:
//     slave  - arbiter view. Takes requests and memory responses, and drives
//              gnt/rvalid/rdata, the mem_* command and timeout_err.
//     master - environment view (core plus memory). This is the mirror image
//              of the slave view.
//   Signals:
//     i_req/i_addr -> i_gnt, i_rvalid, i_rdata                  fetch side
//     d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid, d_rdata     load/store side
//     mem_req/mem_we/mem_addr/mem_wdata <- mem_rdata, mem_ack   memory port
//     timeout_err                                               sticky watchdog flag
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  logic          timeout_err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between the instruction-fetch (i_*) and the
//   load/store (d_*) requesters. Each access runs in three steps: grant,
//   then hold mem_req until mem_ack, then return the data. A watchdog aborts
//   any access that stays busy for TIMEOUT_CYC cycles. Setting TIMEOUT_CYC
//   to 0 disables the watchdog.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous reset, active low
//     bus  - mem_port_arbiter_if.slave (requesters, memory port, timeout_err)
//   Build option:
//     ARB_ROUND_ROBIN_EN - when defined, a simultaneous request goes to the
//     side that did not own the last completed access. When undefined, the
//     data side always wins.
//
//   state  | meaning
//   IDLE   | no access in flight; sampling requests
//   BUSY_I | fetch access on the memory port
//   BUSY_D | load/store access on the memory port
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN = 1'b1;
`else
  localparam bit ROUND_ROBIN = 1'b0;
`endif

  // The count runs from 0 to TIMEOUT_CYC-1. The abort fires on the edge
  // that closes the last allowed busy cycle.
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t          state_q, state_d;
  owner_t          last_owner_q;
  logic [WD_W-1:0] wd_cnt_q;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [DW-1:0]   wdata_q;
  logic            i_gnt_q, d_gnt_q, i_rvalid_q, d_rvalid_q, timeout_err_q;
  logic [DW-1:0]   i_rdata_q, d_rdata_q;

  logic pick_d, grant_i, grant_d, done, abort, busy, wd_hit;

  assign busy   = (state_q != IDLE);
  assign wd_hit = (TIMEOUT_CYC != 0) && (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));
  assign pick_d = bus.d_req &&
                  (!bus.i_req || !ROUND_ROBIN || last_owner_q == OWN_I);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          grant_d = 1'b1;
          state_d = BUSY_D;
        end else if (bus.i_req) begin
          grant_i = 1'b1;
          state_d = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        // An ack wins over a watchdog expiry in the same cycle.
        if (bus.mem_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (wd_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_q  <= OWN_D;
      wd_cnt_q      <= '0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      i_gnt_q       <= 1'b0;
      d_gnt_q       <= 1'b0;
      i_rvalid_q    <= 1'b0;
      d_rvalid_q    <= 1'b0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      i_gnt_q    <= grant_i;
      d_gnt_q    <= grant_d;
      i_rvalid_q <= (done || abort) && (state_q == BUSY_I);
      d_rvalid_q <= (done || abort) && (state_q == BUSY_D);

      if (grant_d) begin
        addr_q  <= bus.d_addr;
        we_q    <= bus.d_we;
        wdata_q <= bus.d_wdata;
      end else if (grant_i) begin
        addr_q  <= bus.i_addr;
        we_q    <= 1'b0;
        wdata_q <= '0;
      end

      if (grant_i || grant_d) wd_cnt_q <= '0;
      else if (busy)          wd_cnt_q <= wd_cnt_q + WD_W'(1);

      // rdata holds between completions. An aborted access returns 0, and so
      // does a store.
      if ((done || abort) && state_q == BUSY_I)
        i_rdata_q <= done ? bus.mem_rdata : '0;
      if ((done || abort) && state_q == BUSY_D)
        d_rdata_q <= (done && !we_q) ? bus.mem_rdata : '0;

      if (done) last_owner_q <= (state_q == BUSY_I) ? OWN_I : OWN_D;
      if (abort) timeout_err_q <= 1'b1;
    end
  end

  assign bus.mem_req     = busy;
  assign bus.mem_we      = busy && we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.i_gnt       = i_gnt_q;
  assign bus.d_gnt       = d_gnt_q;
  assign bus.i_rvalid    = i_rvalid_q;
  assign bus.d_rvalid    = d_rvalid_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter with TIMEOUT_CYC=8. Each expected
//   completion is pushed to a scoreboard when its access is driven. A negedge
//   monitor pops an entry on every rvalid and compares it. The arbitration
//   order that the bench expects follows ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic          side;  // 0 = fetch, 1 = data
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic side, input logic [DW-1:0] data);
    exp_t e;
    e.side = side;
    e.data = data;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && (bus.i_rvalid || bus.d_rvalid)) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_spurious_rvalid", {bus.i_rvalid, bus.d_rvalid}, 2'b00);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_side", {bus.i_rvalid, bus.d_rvalid}, e.side ? 2'b01 : 2'b10);
        check_eq("sb_rdata", e.side ? bus.d_rdata : bus.i_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, {bus.i_gnt, bus.i_rvalid, bus.d_gnt, bus.d_rvalid,
                             bus.mem_req, bus.mem_we, bus.timeout_err}, 7'b0);
    check_eq({tag, "_mem_addr"},  bus.mem_addr,  0);
    check_eq({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check_eq({tag, "_rdata"},     {bus.i_rdata, bus.d_rdata}, 0);
  endtask

  // One complete access. The ack arrives lat cycles after the grant cycle.
  task automatic access(input logic side, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int lat,
                        input logic [DW-1:0] rdata, input string tag);
    if (side) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = addr;
    end
    tick();
    check_eq({tag, "_gnt"}, {bus.i_gnt, bus.d_gnt}, side ? 2'b01 : 2'b10);
    check_eq({tag, "_mem_req"}, bus.mem_req, 1);
    check_eq({tag, "_mem_addr"}, bus.mem_addr, addr);
    check_eq({tag, "_mem_we"}, bus.mem_we, side & we);
    if (side && we) check_eq({tag, "_mem_wdata"}, bus.mem_wdata, wdata);
    // Scramble the requester inputs so the bench catches a mem_* path that
    // is not latched.
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    bus.i_addr = ~addr; bus.d_addr = ~addr; bus.d_wdata = ~wdata; bus.d_we = ~we;
    sb_push(side, (side && we) ? '0 : rdata);
    for (int k = 0; k < lat; k++) begin
      tick();
      check_eq({tag, "_req_hold"}, {bus.mem_req, bus.i_gnt, bus.d_gnt}, 3'b100);
      check_eq({tag, "_addr_hold"}, bus.mem_addr, addr);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'hBAD0_BAD0;
    check_eq({tag, "_req_drop"}, bus.mem_req, 0);
    check_eq({tag, "_rvalid_time"}, {bus.i_rvalid, bus.d_rvalid}, side ? 2'b01 : 2'b10);
    tick();
    bus.d_we = 1'b0;
  endtask

  initial begin
    int cnt;
    logic exp_side;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    // 1: reset in the middle of a busy data access
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h3000;
    tick();
    check_eq("t1_gnt", bus.d_gnt, 1);
    bus.d_req = 1'b0;
    tick(); tick();
    check_eq("t1_busy", bus.mem_req, 1);
    rst = 1'b0;
    #1;
    check_all_zero("t1_rst");
    tick();
    rst = 1'b1;
    tick(); tick();
    check_eq("t1_after", {bus.mem_req, bus.d_rvalid, bus.i_rvalid}, 3'b000);

    // 2: fetch, ack 3 cycles after mem_req
    access(1'b0, 1'b0, 32'h100, 32'h0, 3, 32'h0050_0093, "t2");
    // 3: store, immediate ack, d_rdata must read 0
    access(1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 0, 32'hCAFE_F00D, "t3");
    check_eq("rdata_hold", bus.i_rdata, 32'h0050_0093);

    // mem_ack while IDLE is ignored
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_2222;
    tick(); tick();
    check_eq("idle_ack", {bus.mem_req, bus.i_rvalid, bus.d_rvalid}, 3'b000);
    bus.mem_ack = 1'b0;
    tick();

    // 4: both requests held for four accesses
    bus.i_req = 1'b1; bus.i_addr = 32'h400;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h5000;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_side = RR ? k[0] : 1'b1;
      check_eq($sformatf("t4_gnt%0d", k), {bus.i_gnt, bus.d_gnt}, exp_side ? 2'b01 : 2'b10);
      check_eq($sformatf("t4_addr%0d", k), bus.mem_addr, exp_side ? 32'h5000 : 32'h400);
      sb_push(exp_side, 32'h1000 + k);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1000 + k;
      tick();
      bus.mem_ack = 1'b0;
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick();

    // 5: watchdog abort on a load that never completes
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h6000;
    tick();
    check_eq("t5_gnt", bus.d_gnt, 1);
    bus.d_req = 1'b0;
    sb_push(1'b1, '0);
    cnt = 0;
    for (int k = 0; k < 20 && bus.mem_req; k++) begin
      cnt++;
      tick();
    end
    check_eq("t5_req_cycles", cnt, TO);
    check_eq("t5_rvalid", {bus.i_rvalid, bus.d_rvalid}, 2'b01);
    check_eq("t5_timeout_err", bus.timeout_err, 1);
    tick();
    access(1'b0, 1'b0, 32'h180, 32'h0, 1, 32'h0000_0013, "t5b");
    check_eq("t5_sticky", bus.timeout_err, 1);
    rst = 1'b0;
    #1;
    check_all_zero("t5_rst");
    tick();
    rst = 1'b1;
    tick();

    // 6: ack lands in the same cycle the watchdog would expire
    access(1'b0, 1'b0, 32'h700, 32'h0, TO - 1, 32'h1234_5678, "t6");
    check_eq("t6_no_err", bus.timeout_err, 0);
    tick();

    check_eq("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
